// File: rtl/axi_lite_ram_ctrl.sv
// AXI4-Lite slave front-end for the slot RAM: decodes byte addresses into slots and
// sequences independent write and read channels onto the RAM's native ports.
module axi_lite_ram_ctrl #(
    parameter int NUM_SLOTS        = 6,
    parameter int DATA_WIDTH_BYTES = 4,
    parameter int AXI_ADDR_WIDTH   = 32,
    localparam int SLOT_BITS       = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
    localparam int DATA_BITS       = DATA_WIDTH_BYTES * 8,
    localparam int OFFS            = $clog2(DATA_WIDTH_BYTES)
) (
    input  logic                        clk,
    input  logic                        rst,

    input  logic [AXI_ADDR_WIDTH-1:0]   s_awaddr,
    input  logic                        s_awvalid,
    output logic                        s_awready,
    input  logic [DATA_BITS-1:0]        s_wdata,
    input  logic [DATA_WIDTH_BYTES-1:0] s_wstrb,
    input  logic                        s_wvalid,
    output logic                        s_wready,
    output logic [1:0]                  s_bresp,
    output logic                        s_bvalid,
    input  logic                        s_bready,

    input  logic [AXI_ADDR_WIDTH-1:0]   s_araddr,
    input  logic                        s_arvalid,
    output logic                        s_arready,
    output logic [DATA_BITS-1:0]        s_rdata,
    output logic [1:0]                  s_rresp,
    output logic                        s_rvalid,
    input  logic                        s_rready,

    output logic                        ram_w_en,
    output logic [SLOT_BITS-1:0]        ram_w_addr,
    output logic [DATA_BITS-1:0]        ram_w_data,
    output logic [DATA_WIDTH_BYTES-1:0] ram_w_strb,
    output logic                        ram_r_en,
    output logic [SLOT_BITS-1:0]        ram_r_addr,
    input  logic [DATA_BITS-1:0]        ram_r_data
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_WRITE, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_READ, R_RESP} r_state_t;

    w_state_t w_state;
    r_state_t r_state;

    // Range check uses the whole shifted address so aliasing high bits are rejected.
    function automatic logic in_range(input logic [AXI_ADDR_WIDTH-1:0] addr);
        logic [AXI_ADDR_WIDTH-1:0] slot;
        slot = addr >> OFFS;
        return slot < AXI_ADDR_WIDTH'(NUM_SLOTS);
    endfunction

    logic                        aw_vld_p0;
    logic                        w_vld_p0;
    logic                        aw_oor_p0;
    logic [SLOT_BITS-1:0]        aw_slot_p0;
    logic [DATA_BITS-1:0]        w_data_p0;
    logic [DATA_WIDTH_BYTES-1:0] w_strb_p0;
    logic                        r_oor_p0;
    logic [SLOT_BITS-1:0]        ar_slot_p0;

    logic aw_hs;
    logic w_hs;
    logic ar_hs;

    assign s_awready = !rst && (w_state == W_IDLE) && !aw_vld_p0;
    assign s_wready  = !rst && (w_state == W_IDLE) && !w_vld_p0;
    assign s_arready = !rst && (r_state == R_IDLE);

    assign aw_hs = s_awvalid && s_awready;
    assign w_hs  = s_wvalid && s_wready;
    assign ar_hs = s_arvalid && s_arready;

    assign ram_w_addr = aw_slot_p0;
    assign ram_w_data = w_data_p0;
    assign ram_w_strb = w_strb_p0;
    assign ram_r_addr = ar_slot_p0;

    // Capture stage: payload registers load only on their handshake.
    always_ff @(posedge clk) begin
        if (aw_hs) begin
            aw_slot_p0 <= s_awaddr[OFFS +: SLOT_BITS];
            aw_oor_p0  <= !in_range(s_awaddr);
        end
        if (w_hs) begin
            w_data_p0 <= s_wdata;
            w_strb_p0 <= s_wstrb;
        end
        if (ar_hs) begin
            ar_slot_p0 <= s_araddr[OFFS +: SLOT_BITS];
            r_oor_p0   <= !in_range(s_araddr);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state   <= W_IDLE;
            aw_vld_p0 <= 1'b0;
            w_vld_p0  <= 1'b0;
            ram_w_en  <= 1'b0;
            s_bvalid  <= 1'b0;
            s_bresp   <= RESP_OKAY;
        end else begin
            ram_w_en <= 1'b0;
            case (w_state)
                W_IDLE: begin
                    if (aw_hs) aw_vld_p0 <= 1'b1;
                    if (w_hs)  w_vld_p0  <= 1'b1;
                    if ((aw_vld_p0 || aw_hs) && (w_vld_p0 || w_hs)) begin
                        w_state  <= W_WRITE;
                        ram_w_en <= aw_hs ? in_range(s_awaddr) : !aw_oor_p0;
                    end
                end
                W_WRITE: begin
                    s_bresp  <= aw_oor_p0 ? RESP_SLVERR : RESP_OKAY;
                    s_bvalid <= 1'b1;
                    w_state  <= W_RESP;
                end
                W_RESP: begin
                    if (s_bready) begin
                        s_bvalid  <= 1'b0;
                        aw_vld_p0 <= 1'b0;
                        w_vld_p0  <= 1'b0;
                        w_state   <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Read stage: RAM data is combinational, so it is sampled at the edge ending R_READ,
    // which also makes a coinciding same-slot write invisible to this read.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= R_IDLE;
            ram_r_en <= 1'b0;
            s_rvalid <= 1'b0;
            s_rresp  <= RESP_OKAY;
            s_rdata  <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        r_state  <= R_READ;
                        ram_r_en <= in_range(s_araddr);
                    end
                end
                R_READ: begin
                    ram_r_en <= 1'b0;
                    s_rdata  <= r_oor_p0 ? '0 : ram_r_data;
                    s_rresp  <= r_oor_p0 ? RESP_SLVERR : RESP_OKAY;
                    s_rvalid <= 1'b1;
                    r_state  <= R_RESP;
                end
                R_RESP: begin
                    if (s_rready) begin
                        s_rvalid <= 1'b0;
                        r_state  <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_ram_ctrl.sv
// Self-checking bench for axi_lite_ram_ctrl: behavioural RAM on the native ports and a
// transaction-level reference memory for expected responses.
module tb_axi_lite_ram_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_awaddr;
    logic        s_awvalid;
    logic        s_awready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wvalid;
    logic        s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready;
    logic [31:0] s_araddr;
    logic        s_arvalid;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        s_rready;
    logic        ram_w_en;
    logic [2:0]  ram_w_addr;
    logic [31:0] ram_w_data;
    logic [3:0]  ram_w_strb;
    logic        ram_r_en;
    logic [2:0]  ram_r_addr;
    logic [31:0] ram_r_data;

    int checks = 0;
    int errors = 0;

    axi_lite_ram_ctrl dut (
        .clk(clk), .rst(rst),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .ram_w_en(ram_w_en), .ram_w_addr(ram_w_addr), .ram_w_data(ram_w_data),
        .ram_w_strb(ram_w_strb), .ram_r_en(ram_r_en), .ram_r_addr(ram_r_addr),
        .ram_r_data(ram_r_data)
    );

    always #5 clk = ~clk;

    // Slot RAM stand-in: byte-strobed write at the clock edge, combinational read.
    logic [31:0] ram [0:5];
    assign ram_r_data = (ram_r_addr < 3'd6) ? ram[ram_r_addr] : 32'h0;
    always @(posedge clk) begin
        if (ram_w_en && ram_w_addr < 3'd6)
            for (int b = 0; b < 4; b++)
                if (ram_w_strb[b]) ram[ram_w_addr][8*b +: 8] <= ram_w_data[8*b +: 8];
    end

    int          cyc_cnt = 0;
    int          wen_cnt = 0;
    int          ren_cnt = 0;
    int          last_wen_cyc = 0;
    logic [2:0]  last_wslot;
    logic [31:0] last_wdata;
    logic [3:0]  last_wstrb;
    always @(posedge clk) begin
        cyc_cnt++;
        if (ram_w_en) begin
            wen_cnt++;
            last_wen_cyc = cyc_cnt;
            last_wslot = ram_w_addr;
            last_wdata = ram_w_data;
            last_wstrb = ram_w_strb;
        end
        if (ram_r_en) ren_cnt++;
    end

    // Reference model: byte-addressed slots of 4 bytes, six of them.
    logic [31:0] ref_mem [0:5];

    function automatic logic [1:0] ref_write(input logic [31:0] addr, input logic [31:0] data,
                                             input logic [3:0] strb);
        int unsigned slot = addr / 4;
        if (slot >= 6) return 2'b10;
        for (int b = 0; b < 4; b++)
            if (strb[b]) ref_mem[slot][8*b +: 8] = data[8*b +: 8];
        return 2'b00;
    endfunction

    function automatic logic [1:0] ref_read(input logic [31:0] addr, output logic [31:0] data);
        int unsigned slot = addr / 4;
        if (slot >= 6) begin
            data = 32'h0;
            return 2'b10;
        end
        data = ref_mem[slot];
        return 2'b00;
    endfunction

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int w_lead, input int b_delay,
                            output logic [1:0] resp, output bit timeout, output bit bad);
        bit aw_done = 0, w_done = 0, awhs, whs;
        int n = 0;
        logic [1:0] r0;
        resp = 2'b11; timeout = 0; bad = 0;
        s_awaddr = addr; s_wdata = data; s_wstrb = strb;
        s_wvalid = 1'b1; s_awvalid = (w_lead == 0);
        while (!(aw_done && w_done) && n < 40) begin
            awhs = s_awvalid && s_awready;
            whs  = s_wvalid && s_wready;
            @(posedge clk); #1; n++;
            if (awhs) begin aw_done = 1; s_awvalid = 1'b0; end
            if (whs)  begin w_done = 1;  s_wvalid = 1'b0;  end
            if (!aw_done && n >= w_lead) s_awvalid = 1'b1;
            if ((w_done && s_wready) || (aw_done && s_awready)) bad = 1;
        end
        if (!(aw_done && w_done)) begin
            timeout = 1; s_awvalid = 1'b0; s_wvalid = 1'b0;
            return;
        end
        n = 0;
        while (!s_bvalid && n < 20) begin
            @(posedge clk); #1; n++;
            if (s_wready || s_awready) bad = 1;
        end
        if (!s_bvalid) begin timeout = 1; return; end
        r0 = s_bresp;
        repeat (b_delay) begin
            @(posedge clk); #1;
            if (!s_bvalid || s_bresp !== r0 || s_awready || s_wready) bad = 1;
        end
        resp = r0;
        s_bready = 1'b1;
        @(posedge clk); #1;
        s_bready = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, input int r_delay,
                           output logic [31:0] data, output logic [1:0] resp, output int lat,
                           output bit timeout, output bit bad);
        int n = 0;
        logic [31:0] d0;
        logic [1:0]  r0;
        data = 32'hx; resp = 2'b11; lat = 0; timeout = 0; bad = 0;
        s_araddr = addr; s_arvalid = 1'b1;
        while (!s_arready && n < 20) begin @(posedge clk); #1; n++; end
        if (!s_arready) begin timeout = 1; s_arvalid = 1'b0; return; end
        @(posedge clk); #1;
        s_arvalid = 1'b0;
        if (s_arready) bad = 1;
        while (!s_rvalid && lat < 20) begin
            @(posedge clk); #1; lat++;
            if (s_arready) bad = 1;
        end
        if (!s_rvalid) begin timeout = 1; return; end
        d0 = s_rdata; r0 = s_rresp;
        repeat (r_delay) begin
            @(posedge clk); #1;
            if (!s_rvalid || s_rdata !== d0 || s_rresp !== r0 || s_arready) bad = 1;
        end
        data = d0; resp = r0;
        s_rready = 1'b1;
        @(posedge clk); #1;
        s_rready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({s_bvalid, s_rvalid, ram_w_en, ram_r_en} !== 4'b0) begin
            errors++; $display("FAIL reset_valids: got %b want 0000", {s_bvalid, s_rvalid, ram_w_en, ram_r_en});
        end
        checks++;
        if ({s_bresp, s_rresp, s_rdata} !== 36'h0) begin
            errors++; $display("FAIL reset_payload: got bresp %b rresp %b rdata %h want zeros", s_bresp, s_rresp, s_rdata);
        end
        checks++;
        if ({s_awready, s_wready, s_arready} !== 3'b000) begin
            errors++; $display("FAIL reset_readies_low: got %b want 000", {s_awready, s_wready, s_arready});
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({s_awready, s_wready, s_arready} !== 3'b111) begin
            errors++; $display("FAIL reset_readies_high: got %b want 111", {s_awready, s_wready, s_arready});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [1:0] resp, eresp; logic [31:0] d, ed; bit to, bad; int lat, w0, r0;
        w0 = wen_cnt; r0 = ren_cnt;
        do_write(32'h08, 32'hDEADBEEF, 4'hF, 0, 0, resp, to, bad);
        eresp = ref_write(32'h08, 32'hDEADBEEF, 4'hF);
        checks++;
        if (to || bad || resp !== eresp) begin
            errors++; $display("FAIL basic_bresp: got %b to=%0d bad=%0d want %b", resp, to, bad, eresp);
        end
        checks++;
        if (wen_cnt - w0 != 1 || last_wslot !== 3'd2 || last_wdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL basic_wen: got pulses %0d slot %0d data %h want 1 2 deadbeef", wen_cnt - w0, last_wslot, last_wdata);
        end
        do_read(32'h08, 0, d, resp, lat, to, bad);
        eresp = ref_read(32'h08, ed);
        checks++;
        if (to || bad || d !== ed || resp !== eresp) begin
            errors++; $display("FAIL basic_read: got %h/%b want %h/%b (to=%0d bad=%0d)", d, resp, ed, eresp, to, bad);
        end
        checks++;
        if (lat != 1 || ren_cnt - r0 != 1) begin
            errors++; $display("FAIL basic_read_timing: got lat %0d ren %0d want 1 1", lat, ren_cnt - r0);
        end
    endtask

    task automatic test_w_first();
        logic [1:0] resp, eresp; bit to, bad; int w0;
        w0 = wen_cnt;
        do_write(32'h04, 32'h11223344, 4'b0101, 3, 0, resp, to, bad);
        eresp = ref_write(32'h04, 32'h11223344, 4'b0101);
        checks++;
        if (to || bad || resp !== eresp) begin
            errors++; $display("FAIL wfirst_resp: got %b to=%0d ready_bad=%0d want %b", resp, to, bad, eresp);
        end
        checks++;
        if (wen_cnt - w0 != 1 || last_wslot !== 3'd1 || last_wstrb !== 4'b0101 || last_wdata !== 32'h11223344) begin
            errors++; $display("FAIL wfirst_wen: got n=%0d slot %0d strb %b data %h", wen_cnt - w0, last_wslot, last_wstrb, last_wdata);
        end
    endtask

    task automatic test_out_of_range();
        logic [1:0] resp; logic [31:0] d; bit to, bad; int lat, w0, r0;
        w0 = wen_cnt;
        do_write(32'h18, 32'h55555555, 4'hF, 0, 0, resp, to, bad);
        checks++;
        if (to || resp !== 2'b10 || wen_cnt != w0) begin
            errors++; $display("FAIL oor_write: got bresp %b pulses %0d want 10 0", resp, wen_cnt - w0);
        end
        do_write(32'h80000008, 32'h66666666, 4'hF, 1, 0, resp, to, bad);
        checks++;
        if (to || resp !== 2'b10 || wen_cnt != w0) begin
            errors++; $display("FAIL oor_write_high: got bresp %b pulses %0d want 10 0", resp, wen_cnt - w0);
        end
        r0 = ren_cnt;
        do_read(32'h40, 0, d, resp, lat, to, bad);
        checks++;
        if (to || d !== 32'h0 || resp !== 2'b10 || ren_cnt != r0) begin
            errors++; $display("FAIL oor_read: got %h/%b ren %0d want 0/10 0", d, resp, ren_cnt - r0);
        end
    endtask

    task automatic test_backpressure();
        logic [1:0] resp, eresp; logic [31:0] d, ed; bit to, bad; int lat;
        do_write(32'h14, 32'hA5A5F00F, 4'hF, 0, 5, resp, to, bad);
        eresp = ref_write(32'h14, 32'hA5A5F00F, 4'hF);
        checks++;
        if (to || bad || resp !== eresp) begin
            errors++; $display("FAIL bp_write: got %b stable_bad=%0d to=%0d want %b", resp, bad, to, eresp);
        end
        do_read(32'h17, 5, d, resp, lat, to, bad);
        eresp = ref_read(32'h17, ed);
        checks++;
        if (to || bad || d !== ed || resp !== eresp) begin
            errors++; $display("FAIL bp_read: got %h/%b stable_bad=%0d want %h/%b", d, resp, bad, ed, eresp);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] resp; bit to, bad; int c1;
        do_write(32'h00, 32'h01010101, 4'hF, 0, 0, resp, to, bad);
        void'(ref_write(32'h00, 32'h01010101, 4'hF));
        c1 = last_wen_cyc;
        do_write(32'h00, 32'h02020202, 4'h3, 0, 0, resp, to, bad);
        void'(ref_write(32'h00, 32'h02020202, 4'h3));
        checks++;
        if (to || last_wen_cyc - c1 != 3) begin
            errors++; $display("FAIL b2b_spacing: got %0d cycles want 3", last_wen_cyc - c1);
        end
    endtask

    task automatic test_collision();
        logic [1:0] resp; logic [31:0] d, ed; bit to, bad; int lat;
        do_write(32'h0C, 32'hAAAA5555, 4'hF, 0, 0, resp, to, bad);
        void'(ref_write(32'h0C, 32'hAAAA5555, 4'hF));
        s_awaddr = 32'h0C; s_wdata = 32'h12345678; s_wstrb = 4'hF; s_araddr = 32'h0C;
        s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
        @(posedge clk); #1;
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
        checks++;
        if ({ram_w_en, ram_r_en} !== 2'b11) begin
            errors++; $display("FAIL coll_overlap: got w_en/r_en %b want 11", {ram_w_en, ram_r_en});
        end
        @(posedge clk); #1;
        checks++;
        if (!s_rvalid || s_rdata !== 32'hAAAA5555 || s_rresp !== 2'b00) begin
            errors++; $display("FAIL coll_old_value: got v=%b %h/%b want 1 aaaa5555/00", s_rvalid, s_rdata, s_rresp);
        end
        s_bready = 1'b1; s_rready = 1'b1;
        @(posedge clk); #1;
        s_bready = 1'b0; s_rready = 1'b0;
        void'(ref_write(32'h0C, 32'h12345678, 4'hF));
        do_read(32'h0C, 0, d, resp, lat, to, bad);
        void'(ref_read(32'h0C, ed));
        checks++;
        if (to || d !== ed) begin
            errors++; $display("FAIL coll_new_value: got %h want %h", d, ed);
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] resp; logic [31:0] d, ed; bit to, bad, stuck; int lat, w0;
        s_awaddr = 32'h10; s_wdata = 32'hCAFEF00D; s_wstrb = 4'hF;
        s_awvalid = 1'b1; s_wvalid = 1'b1;
        @(posedge clk); #1;
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        s_araddr = 32'h10; s_arvalid = 1'b1;
        @(posedge clk); #1;
        s_arvalid = 1'b0;
        void'(ref_write(32'h10, 32'hCAFEF00D, 4'hF));
        w0 = wen_cnt;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({s_bvalid, s_rvalid, ram_w_en, ram_r_en} !== 4'b0) begin
            errors++; $display("FAIL midrst_abort: got %b want 0000", {s_bvalid, s_rvalid, ram_w_en, ram_r_en});
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({s_awready, s_wready, s_arready} !== 3'b111) begin
            errors++; $display("FAIL midrst_readies: got %b want 111", {s_awready, s_wready, s_arready});
        end
        stuck = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (s_bvalid || s_rvalid) stuck = 1;
        end
        checks++;
        if (stuck || wen_cnt != w0) begin
            errors++; $display("FAIL midrst_quiet: got resp_seen=%0d extra_wen=%0d want 0 0", stuck, wen_cnt - w0);
        end
        do_read(32'h10, 0, d, resp, lat, to, bad);
        void'(ref_read(32'h10, ed));
        checks++;
        if (to || d !== ed) begin
            errors++; $display("FAIL midrst_readback: got %h want %h", d, ed);
        end
    endtask

    task automatic test_random();
        logic [1:0] resp, eresp; logic [31:0] addr, data, d, ed; logic [3:0] strb;
        bit to, bad; int lat, w0;
        for (int i = 0; i < 30; i++) begin
            addr = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 31));
            data = $urandom;
            strb = 4'($urandom_range(0, 15));
            w0 = wen_cnt;
            do_write(addr, data, strb, $urandom_range(0, 3), $urandom_range(0, 3), resp, to, bad);
            eresp = ref_write(addr, data, strb);
            checks++;
            if (to || bad || resp !== eresp || (wen_cnt - w0) != ((eresp == 2'b00) ? 1 : 0)) begin
                errors++; $display("FAIL rand_write[%0d]: addr %h got %b pulses %0d want %b", i, addr, resp, wen_cnt - w0, eresp);
            end
            addr = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 31));
            do_read(addr, $urandom_range(0, 3), d, resp, lat, to, bad);
            eresp = ref_read(addr, ed);
            checks++;
            if (to || bad || lat != 1 || d !== ed || resp !== eresp) begin
                errors++; $display("FAIL rand_read[%0d]: addr %h got %h/%b lat %0d want %h/%b", i, addr, d, resp, lat, ed, eresp);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 6; i++) begin
            ram[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end
        rst = 1'b1;
        s_awaddr = '0; s_awvalid = 0; s_wdata = '0; s_wstrb = '0; s_wvalid = 0; s_bready = 0;
        s_araddr = '0; s_arvalid = 0; s_rready = 0;
        test_reset();
        test_basic();
        test_w_first();
        test_out_of_range();
        test_backpressure();
        test_back_to_back();
        test_collision();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
